// File: rtl/iterative_divider_if.sv
// rtl/iterative_divider_if.sv - request/result handshake bundle for the iterative divider
interface iterative_divider_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag_out;
    logic             busy;

    modport slave (
        input  in_valid, op, dividend, divisor, tag_in, out_ready,
        output in_ready, out_valid, result, tag_out, busy
    );

    modport master (
        output in_valid, op, dividend, divisor, tag_in, out_ready,
        input  in_ready, out_valid, result, tag_out, busy
    );
endinterface

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - restoring multi-cycle DIV/DIVU/REM/REMU unit, one quotient bit per cycle
module iterative_divider #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    iterative_divider_if.slave  bus
);
    localparam int                CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e           r_state;
    logic [1:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_overflow;
    logic [WIDTH:0]   w_partial;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_in_ready = (r_state == S_IDLE) && !flush;
    assign w_accept   = bus.in_valid && w_in_ready;

    // op[0] clear selects the signed variants (DIV, REM)
    assign w_signed   = ~bus.op[0];
    assign w_a_neg    = w_signed & bus.dividend[WIDTH-1];
    assign w_b_neg    = w_signed & bus.divisor[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -bus.dividend : bus.dividend;
    assign w_b_mag    = w_b_neg ? -bus.divisor  : bus.divisor;
    assign w_div_zero = (bus.divisor == '0);
    assign w_overflow = w_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
    assign w_partial  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = {1'b0, w_partial} - {2'b00, r_dvs};
    assign w_fits     = ~w_diff[WIDTH+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_tag   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.op;
                        r_tag <= bus.tag_in;
                        r_cnt <= '0;
                        r_dvs <= w_b_mag;
                        if (w_div_zero) begin
                            r_quo   <= '1;
                            r_rem   <= bus.dividend;
                            r_q_neg <= 1'b0;
                            r_r_neg <= 1'b0;
                            r_state <= S_DONE;
                        end else if (w_overflow) begin
                            r_quo   <= bus.dividend;
                            r_rem   <= '0;
                            r_q_neg <= 1'b0;
                            r_r_neg <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_quo   <= w_a_mag;
                            r_rem   <= '0;
                            r_q_neg <= w_a_neg ^ w_b_neg;
                            r_r_neg <= w_a_neg;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_fits};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_quo_fix     = r_q_neg ? -r_quo : r_quo;
    assign w_rem_fix     = r_r_neg ? -r_rem : r_rem;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.result    = r_op[1] ? w_rem_fix : w_quo_fix;
    assign bus.tag_out   = r_tag;
endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - randomized and directed checks of iterative_divider against an arithmetic model
module tb_iterative_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic rst_n8 = 1'b0;
    logic flush8 = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic rand_mode = 1'b0;

    iterative_divider_if #(.WIDTH(32), .TAG_W(5)) dif ();
    iterative_divider_if #(.WIDTH(8),  .TAG_W(5)) dif8 ();

    iterative_divider #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(dif)
    );
    iterative_divider #(.WIDTH(8), .TAG_W(5)) dut8 (
        .clk(clk), .rst_n(rst_n8), .flush(flush8), .bus(dif8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
        case (o)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // Edge (counted from the accept edge) after which out_valid is first seen
    function automatic int ref_valid_edge(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return is_special(o, a, b) ? 0 : 32;
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        int          vedge;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        logic ev;
        ev = 1'b0;
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", dif.out_valid, 0);
            chk("rst_busy", dif.busy, 0);
            chk("rst_in_ready", dif.in_ready, !flush);
            chk("rst_result", dif.result, 0);
            chk("rst_tag_out", dif.tag_out, 0);
        end else begin
            chk("busy", dif.busy, q.size() != 0);
            chk("in_ready", dif.in_ready, (q.size() == 0) && !flush);
            if (q.size() != 0) begin
                ev = (cyc - q[0].acc) >= q[0].vedge;
                chk("out_valid", dif.out_valid, ev);
                if (ev) begin
                    chk("result", dif.result, q[0].res);
                    chk("tag_out", dif.tag_out, q[0].tag);
                end
            end else begin
                chk("out_valid_idle", dif.out_valid, 0);
            end
            if (flush) begin
                q.delete();
            end else if (q.size() == 0) begin
                if (dif.in_valid) begin
                    q.push_back('{ref_div(dif.op, dif.dividend, dif.divisor), dif.tag_in, cyc + 1,
                                  ref_valid_edge(dif.op, dif.dividend, dif.divisor)});
                end
            end else if (ev && dif.out_ready) begin
                void'(q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                dif.out_ready = ($urandom % 3) != 0;
                flush = ($urandom % 60) == 0;
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        int n;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b1;
        dif.op = o;
        dif.dividend = a;
        dif.divisor = b;
        dif.tag_in = t;
        n = 0;
        @(negedge clk);
        while (!dif.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        dif.op = 2'($urandom);
        dif.dividend = $urandom;
        dif.divisor = $urandom;
        dif.tag_in = 5'($urandom);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                          output logic [31:0] res, output logic [4:0] tag, output int vedge);
        issue(o, a, b, t);
        vedge = 0;
        @(negedge clk);
        while (!dif.out_valid && vedge < 100) begin
            @(negedge clk);
            vedge++;
        end
        if (vedge >= 100) chk("valid_timeout", 1, 0);
        res = dif.result;
        tag = dif.tag_out;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (dif.busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("idle_timeout", 1, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        logic [4:0]  tag;
        int          ve;
        int          e;
        dif.in_valid = 1'b0;  dif.op = 2'b00;  dif.dividend = '0;  dif.divisor = '0;
        dif.tag_in = '0;      dif.out_ready = 1'b1;
        dif8.in_valid = 1'b0; dif8.op = 2'b00; dif8.dividend = '0; dif8.divisor = '0;
        dif8.tag_in = '0;     dif8.out_ready = 1'b1;

        chk("model_div", ref_div(2'b00, 32'd20, -32'sd3), 32'hFFFF_FFFA);
        chk("model_rem", ref_div(2'b10, -32'sd20, 32'd3), 32'hFFFF_FFFE);
        chk("model_ovf", ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("model_divu", ref_div(2'b01, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; rst_n8 = 1'b1;

        run_op(2'b00, 32'd20, -32'sd3, 5'd7, res, tag, ve);
        chk("div_20_m3", res, 32'hFFFF_FFFA); chk("div_tag", tag, 5'd7); chk("div_lat", ve, 32);
        wait_idle();
        run_op(2'b10, 32'd20, -32'sd3, 5'd8, res, tag, ve);
        chk("rem_20_m3", res, 32'd2);
        wait_idle();
        run_op(2'b10, -32'sd20, 32'd3, 5'd9, res, tag, ve);
        chk("rem_m20_3", res, 32'hFFFF_FFFE);
        wait_idle();
        run_op(2'b01, 32'hFFFF_FFFF, 32'd0, 5'd1, res, tag, ve);
        chk("divu_by0", res, 32'hFFFF_FFFF); chk("divu_by0_lat", ve, 0);
        wait_idle();
        run_op(2'b11, 32'h1234, 32'd0, 5'd2, res, tag, ve);
        chk("remu_by0", res, 32'h1234); chk("remu_by0_lat", ve, 0);
        wait_idle();
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, res, tag, ve);
        chk("div_ovf", res, 32'h8000_0000); chk("div_ovf_lat", ve, 0);
        wait_idle();
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, res, tag, ve);
        chk("rem_ovf", res, 32'd0);
        wait_idle();
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, res, tag, ve);
        chk("divu_big", res, 32'd0); chk("divu_big_lat", ve, 32);
        wait_idle();
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, res, tag, ve);
        chk("divu_same", res, 32'd1);
        wait_idle();

        dif.out_ready = 1'b0;
        run_op(2'b01, 32'd1000, 32'd10, 5'd11, res, tag, ve);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result", dif.result, 32'd100);
            chk("bp_tag", dif.tag_out, 5'd11);
            chk("bp_in_ready", dif.in_ready, 0);
        end
        @(posedge clk);
        #1 dif.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_ready", dif.in_ready, 1);
        run_op(2'b01, 32'd77, 32'd7, 5'd12, res, tag, ve);
        chk("b2b_divu", res, 32'd11);
        wait_idle();

        issue(2'b01, 32'hFFFF_0000, 32'd3, 5'd13);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        dif.in_valid = 1'b1; dif.op = 2'b01; dif.dividend = 32'd5; dif.divisor = 32'd1;
        @(negedge clk);
        chk("flush_busy_before", dif.busy, 1);
        @(posedge clk);
        #1 flush = 1'b0; dif.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy_after", dif.busy, 0);
        chk("flush_in_ready", dif.in_ready, 1);
        repeat (40) @(negedge clk);
        run_op(2'b01, 32'd100, 32'd9, 5'd14, res, tag, ve);
        chk("post_flush_divu", res, 32'd11);
        wait_idle();
        @(posedge clk);
        #1 flush = 1'b1; dif.in_valid = 1'b1; dif.op = 2'b01;
        @(negedge clk);
        chk("idle_flush_ready", dif.in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0; dif.in_valid = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", dif.busy, 0);

        rand_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            issue(2'($urandom), pick(), pick(), 5'($urandom));
            wait_idle();
            repeat ($urandom % 3) @(posedge clk);
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #1 flush = 1'b0; dif.out_ready = 1'b1;
        wait_idle();

        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 dif8.in_valid = 1'b1; dif8.op = (k == 0) ? 2'b01 : 2'b11;
            dif8.dividend = 8'd200; dif8.divisor = 8'd7; dif8.tag_in = 5'd21;
            @(negedge clk);
            chk("w8_in_ready", dif8.in_ready, 1);
            @(posedge clk);
            #1 dif8.in_valid = 1'b0; dif8.dividend = 8'd3;
            e = 0;
            @(negedge clk);
            while (!dif8.out_valid && e < 50) begin
                @(negedge clk);
                e++;
            end
            chk("w8_result", dif8.result, (k == 0) ? 8'd28 : 8'd4);
            chk("w8_lat", e, 8);
            chk("w8_tag", dif8.tag_out, 5'd21);
            repeat (2) @(negedge clk);
        end
        @(posedge clk);
        #1 dif8.in_valid = 1'b1; dif8.op = 2'b01; dif8.dividend = 8'd99; dif8.divisor = 8'd5;
        @(posedge clk);
        #1 dif8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("w8_busy_mid", dif8.busy, 1);
        rst_n8 = 1'b0;
        #1;
        chk("w8_rst_busy", dif8.busy, 0);
        chk("w8_rst_valid", dif8.out_valid, 0);
        @(negedge clk);
        rst_n8 = 1'b1;
        @(negedge clk);
        chk("w8_rel_ready", dif8.in_ready, 1);
        chk("w8_rel_busy", dif8.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
